// File: rtl/jedro_1_defines.sv
// Shared state encoding and counter width for the program checker.
package jedro_1_defines;

  localparam int unsigned CYCLE_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_CHECK = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/jedro_1_prog_checker.sv
// Runs a core until halt or timeout, drains the pipeline, then compares
// selected register-file entries against expected values.
module jedro_1_prog_checker
  import jedro_1_defines::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned NUM_CHECKS     = 4,
  parameter int unsigned MAX_CYCLES     = 64,
  parameter int unsigned DRAIN_CYCLES   = 3
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic                                 start_i,
  input  logic                                 halt_i,
  input  logic [NUM_CHECKS*REG_ADDR_WIDTH-1:0] exp_addr_i,
  input  logic [NUM_CHECKS*DATA_WIDTH-1:0]     exp_data_i,
  output logic [REG_ADDR_WIDTH-1:0]            rf_raddr_o,
  input  logic [DATA_WIDTH-1:0]                rf_rdata_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  output logic                                 pass_o,
  output logic                                 timeout_o,
  output logic [NUM_CHECKS-1:0]                fail_mask_o,
  output logic [CYCLE_CNT_WIDTH-1:0]           cycle_cnt_o
);

  localparam int unsigned IDX_W      = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int unsigned DRN_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam int unsigned DRAIN_LAST = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
  localparam int unsigned TIMEOUT_AT = (MAX_CYCLES > 0) ? MAX_CYCLES - 1 : 0;
  localparam int unsigned CNT_W      = CYCLE_CNT_WIDTH;

  state_e                      state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_inc;
  logic [DRN_W-1:0]            drain_q, drain_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [NUM_CHECKS-1:0]       fail_q, fail_d, mis_vec;
  logic                        timeout_q, timeout_d;
  logic                        pass_q, pass_d;
  logic                        busy_q, busy_d;
  logic                        done_q, done_d;
  logic [REG_ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic                        timeout_hit;

  // Next-state, counters and registered outputs
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    idx_d     = idx_q;
    fail_d    = fail_q;
    timeout_d = timeout_q;
    pass_d    = pass_q;
    raddr_d   = '0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    cnt_inc     = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
    timeout_hit = (32'(cnt_inc) >= 32'(TIMEOUT_AT));

    for (int k = 0; k < int'(NUM_CHECKS); k++) begin
      mis_vec[k] = (idx_q == IDX_W'(k)) &&
                   (exp_data_i[k*DATA_WIDTH +: DATA_WIDTH] != rf_rdata_i);
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_i) begin
          state_d   = ST_RUN;
          cnt_d     = '0;
          drain_d   = '0;
          idx_d     = '0;
          fail_d    = '0;
          timeout_d = 1'b0;
          pass_d    = 1'b0;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_inc;
        // halt_i has priority over a coincident timeout
        if (halt_i || timeout_hit) begin
          timeout_d = !halt_i;
          state_d   = (DRAIN_CYCLES == 0) ? ST_CHECK : ST_DRAIN;
          drain_d   = '0;
          idx_d     = '0;
        end
      end
      ST_DRAIN: begin
        if (drain_q == DRN_W'(DRAIN_LAST)) begin
          state_d = ST_CHECK;
          idx_d   = '0;
        end else begin
          drain_d = drain_q + DRN_W'(1);
        end
      end
      ST_CHECK: begin
        fail_d = fail_q | mis_vec;
        if (idx_q == IDX_W'(NUM_CHECKS - 1)) begin
          state_d = ST_DONE;
          pass_d  = (fail_d == '0) && !timeout_q;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Read address is presented for the check index of the coming cycle
    if (state_d == ST_CHECK) begin
      for (int k = 0; k < int'(NUM_CHECKS); k++) begin
        if (idx_d == IDX_W'(k)) raddr_d = exp_addr_i[k*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
      end
    end

    busy_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_CHECK);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      drain_q   <= '0;
      idx_q     <= '0;
      fail_q    <= '0;
      timeout_q <= 1'b0;
      pass_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      raddr_q   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      idx_q     <= idx_d;
      fail_q    <= fail_d;
      timeout_q <= timeout_d;
      pass_q    <= pass_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      raddr_q   <= raddr_d;
    end
  end

  assign rf_raddr_o  = raddr_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign timeout_o   = timeout_q;
  assign fail_mask_o = fail_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_jedro_1_prog_checker.sv
// Directed bench for jedro_1_prog_checker: a default instance and a
// single-check, no-drain instance share one register-file model.
module tb_jedro_1_prog_checker;

  logic        clk;
  logic        rst;
  logic        start0, start1, halt;
  logic [19:0] ea0;
  logic [127:0] ed0;
  logic [4:0]  ea1;
  logic [31:0] ed1;

  logic [4:0]  raddr0, raddr1;
  logic [31:0] rdata0, rdata1;
  logic        busy0, done0, pass0, to0;
  logic        busy1, done1, pass1, to1;
  logic [3:0]  mask0;
  logic [0:0]  mask1;
  logic [15:0] cnt0, cnt1;

  logic [31:0] regs [32];

  int n_pass;
  int n_total;
  int lat;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign rdata0 = regs[raddr0];
  assign rdata1 = regs[raddr1];

  jedro_1_prog_checker u_dut0 (
    .clk_i(clk), .rst_i(rst), .start_i(start0), .halt_i(halt),
    .exp_addr_i(ea0), .exp_data_i(ed0),
    .rf_raddr_o(raddr0), .rf_rdata_i(rdata0),
    .busy_o(busy0), .done_o(done0), .pass_o(pass0), .timeout_o(to0),
    .fail_mask_o(mask0), .cycle_cnt_o(cnt0)
  );

  jedro_1_prog_checker #(
    .NUM_CHECKS(1), .DRAIN_CYCLES(0), .MAX_CYCLES(8)
  ) u_dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .halt_i(halt),
    .exp_addr_i(ea1), .exp_data_i(ed1),
    .rf_raddr_o(raddr1), .rf_rdata_i(rdata1),
    .busy_o(busy1), .done_o(done1), .pass_o(pass1), .timeout_o(to1),
    .fail_mask_o(mask1), .cycle_cnt_o(cnt1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Start a run, raise halt in RUN cycle halt_at (0 = never), probe busy and
  // read address at probe_lat, and return cycles from start edge to done.
  task automatic run(input bit sel, input int halt_at, input int probe_lat,
                     input logic [4:0] probe_addr, output int l);
    logic d;
    d = 1'b0;
    @(negedge clk);
    if (sel) start1 = 1'b1; else start0 = 1'b1;
    l = 0;
    for (int g = 0; g < 300; g++) begin
      @(negedge clk);
      l++;
      start0 = 1'b0;
      start1 = 1'b0;
      d = sel ? done1 : done0;
      if (d) break;
      if (l == probe_lat) begin
        check("probe_busy", 32'(sel ? busy1 : busy0), 32'd1);
        check("probe_raddr", 32'(sel ? raddr1 : raddr0), 32'(probe_addr));
      end
      // A start pulse while running must be ignored
      if (l == 3) begin
        if (sel) start1 = 1'b1; else start0 = 1'b1;
      end
      halt = (l == halt_at);
    end
    halt = 1'b0;
    if (!d) check("run_bound", 32'd0, 32'd1);
  endtask

  task automatic check_result(input string tag, input bit sel, input int exp_lat,
                              input bit exp_pass, input bit exp_to,
                              input int exp_cnt, input int exp_mask);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_pass"}, 32'(sel ? pass1 : pass0), 32'(exp_pass));
    check({tag, "_timeout"}, 32'(sel ? to1 : to0), 32'(exp_to));
    check({tag, "_cnt"}, 32'(sel ? cnt1 : cnt0), 32'(exp_cnt));
    check({tag, "_mask"}, sel ? 32'(mask1) : 32'(mask0), 32'(exp_mask));
    check({tag, "_busy"}, 32'(sel ? busy1 : busy0), 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    rst     = 1'b1;
    start0  = 1'b0;
    start1  = 1'b0;
    halt    = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = 32'h1000 + 32'(i);
    regs[0] = 32'h0;
    regs[2] = 32'h8000_0008;
    regs[3] = 32'h6;
    // slice 0 is the least significant
    ea0 = {5'd2, 5'd0, 5'd3, 5'd2};
    ed0 = {32'h8000_0008, 32'h0, 32'h6, 32'h8000_0008};
    ea1 = 5'd2;
    ed1 = 32'h8000_0008;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_pass", 32'(pass0), 32'd0);
    check("rst_cnt", 32'(cnt0), 32'd0);
    check("rst_raddr", 32'(raddr0), 32'd0);

    // Halt at RUN cycle 10, all checks match
    run(1'b0, 10, 15, 5'd3, lat);
    check_result("halt10", 1'b0, 18, 1'b1, 1'b0, 10, 0);
    repeat (3) @(negedge clk);
    check("done_hold", 32'(done0), 32'd1);
    check("done_hold_cnt", 32'(cnt0), 32'd10);
    check("done_raddr", 32'(raddr0), 32'd0);

    // Register 3 holds 5 while check 1 expects 6
    regs[3] = 32'h5;
    run(1'b0, 10, 5, 5'd0, lat);
    check_result("mismatch", 1'b0, 18, 1'b0, 1'b0, 10, 4'b0010);
    regs[3] = 32'h6;

    // No halt: timeout after MAX_CYCLES-1 run cycles
    run(1'b0, 0, 66, 5'd0, lat);
    check_result("timeout", 1'b0, 71, 1'b0, 1'b1, 63, 0);

    // Halt coincident with timeout: halt wins
    run(1'b0, 63, 0, 5'd0, lat);
    check_result("halt63", 1'b0, 71, 1'b1, 1'b0, 63, 0);

    // Reset pulse while draining
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk); halt = 1'b1;
    @(negedge clk); halt = 1'b0;
    check("drain_busy", 32'(busy0), 32'd1);
    check("drain_cnt", 32'(cnt0), 32'd2);
    rst = 1'b1;
    #1;
    check("arst_busy", 32'(busy0), 32'd0);
    check("arst_done", 32'(done0), 32'd0);
    check("arst_pass", 32'(pass0), 32'd0);
    check("arst_cnt", 32'(cnt0), 32'd0);
    @(negedge clk); rst = 1'b0;
    repeat (3) @(negedge clk);
    check("post_rst_idle", 32'(busy0), 32'd0);
    check("post_rst_done", 32'(done0), 32'd0);
    run(1'b0, 4, 0, 5'd0, lat);
    check_result("after_rst", 1'b0, 12, 1'b1, 1'b0, 4, 0);

    // Single check, no drain: CHECK straight after RUN
    run(1'b1, 5, 6, 5'd2, lat);
    check_result("nc1_halt", 1'b1, 7, 1'b1, 1'b0, 5, 0);
    check("idle_halt_ignored", 32'(cnt0), 32'd4);
    run(1'b1, 0, 0, 5'd0, lat);
    check_result("nc1_timeout", 1'b1, 9, 1'b0, 1'b1, 7, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
